// File: rtl/mul_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// mul_sequencer_pkg
// Shared definitions for the multi-cycle MUL sequencer:
//   - state_t       : sequencer FSM states (IDLE, BUSY, DONE)
//   - MUL_FUNCT     : R-type funct field that decodes to MUL
//   - ALU_OP_MUL    : ALU operation code carried by a MUL
//   - DEFAULT_WIDTH : default operand/result width and iteration count
// No ports (package).
// -----------------------------------------------------------------------------
package mul_sequencer_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic [5:0] MUL_FUNCT  = 6'b101000;
  localparam logic [2:0] ALU_OP_MUL = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : mul_sequencer_pkg

// File: rtl/mul_sequencer_if.sv
// -----------------------------------------------------------------------------
// mul_sequencer_if
// Bundle between the issue/decode stage and the MUL sequencer.
// Signals:
//   start  : decoded MUL in the issue stage (issue -> sequencer)
//   flush  : pipeline flush, aborts any operation (issue -> sequencer)
//   opa    : multiplicand, rs (issue -> sequencer)
//   opb    : multiplier, rt (issue -> sequencer)
//   stall  : holds the pipeline front end (sequencer -> issue)
//   done   : one-cycle pulse, result valid (sequencer -> write-back)
//   result : low WIDTH bits of opa*opb (sequencer -> write-back)
//   busy   : sequencer not idle (sequencer -> pipeline)
// Modports: master = pipeline side, slave = sequencer side.
// -----------------------------------------------------------------------------
interface mul_sequencer_if
  import mul_sequencer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic             flush;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             busy;

  modport master (
    output start, flush, opa, opb,
    input  stall, done, result, busy
  );

  modport slave (
    input  start, flush, opa, opb,
    output stall, done, result, busy
  );

endinterface : mul_sequencer_if

// File: rtl/mul_sequencer_step.sv
// -----------------------------------------------------------------------------
// mul_step
// One combinational iteration of the shift-add multiply.
// Ports:
//   i_acc, i_mcand, i_mplier : current accumulator / multiplicand / multiplier
//   o_acc, o_mcand, o_mplier : values after this iteration
// The accumulator add is modulo 2^WIDTH; the carry-out is dropped because
// only the low WIDTH bits of the product are ever returned.
// -----------------------------------------------------------------------------
module mul_step
  import mul_sequencer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0] i_mcand,
  input  logic [WIDTH-1:0] i_mplier,
  output logic [WIDTH-1:0] o_acc,
  output logic [WIDTH-1:0] o_mcand,
  output logic [WIDTH-1:0] o_mplier
);

  always_comb begin
    o_acc    = i_mplier[0] ? (i_acc + i_mcand) : i_acc;
    o_mcand  = i_mcand << 1;
    o_mplier = i_mplier >> 1;
  end

endmodule : mul_step

// File: rtl/mul_sequencer.sv
// -----------------------------------------------------------------------------
// mul_sequencer
// Multi-cycle controller for the MUL instruction. Latches the operands on an
// accepted start, runs an iterative shift-add multiply (one mul_step per
// cycle), stalls the front end while working and pulses done with the low
// WIDTH bits of the product.
// Ports:
//   clock : rising-edge clock
//   reset : synchronous, active-high reset (same effect as flush)
//   bus   : mul_sequencer_if.slave (start/flush/opa/opb in,
//           stall/done/result/busy out)
// Build option:
//   MUL_EARLY_EXIT_EN : when defined, BUSY ends as soon as the remaining
//                       multiplier is zero, and opb==0 goes straight to DONE.
//                       Results are identical; only latency changes.
// -----------------------------------------------------------------------------
module mul_sequencer
  import mul_sequencer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic           clock,
  input  logic           reset,
  mul_sequencer_if.slave bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_count;
  logic             r_done;
  logic             r_busy;
  logic [WIDTH-1:0] r_result;

  logic [WIDTH-1:0] w_acc_nxt;
  logic [WIDTH-1:0] w_mcand_nxt;
  logic [WIDTH-1:0] w_mplier_nxt;
  logic             w_last;

  mul_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_acc    (r_acc),
    .i_mcand  (r_mcand),
    .i_mplier (r_mplier),
    .o_acc    (w_acc_nxt),
    .o_mcand  (w_mcand_nxt),
    .o_mplier (w_mplier_nxt)
  );

  // Final BUSY iteration. The count reaches WIDTH-1 on the last of WIDTH
  // steps, so the counter only wraps on the transition out of BUSY.
`ifdef MUL_EARLY_EXIT_EN
  assign w_last = (r_count == LAST_CNT) || (w_mplier_nxt == '0);
`else
  assign w_last = (r_count == LAST_CNT);
`endif

  // Combinational so the issuing MUL is held in its own decode cycle;
  // low in DONE so the instruction can retire.
  assign bus.stall  = ((r_state == IDLE) && bus.start && !bus.flush) ||
                      (r_state == BUSY);
  assign bus.done   = r_done;
  assign bus.busy   = r_busy;
  assign bus.result = r_result;

  always_ff @(posedge clock) begin
    if (reset || bus.flush) begin
      // Abort: back to IDLE without a done pulse. result is only cleared
      // by reset; a flush leaves the last published value untouched.
      r_state <= IDLE;
      r_acc   <= '0;
      r_count <= '0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
      if (reset) begin
        r_result <= '0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_mcand  <= bus.opa;
            r_mplier <= bus.opb;
            r_acc    <= '0;
            r_count  <= '0;
            r_busy   <= 1'b1;
`ifdef MUL_EARLY_EXIT_EN
            if (bus.opb == '0) begin
              r_state  <= DONE;
              r_done   <= 1'b1;
              r_result <= '0;
            end else begin
              r_state  <= BUSY;
            end
`else
            r_state <= BUSY;
`endif
          end
        end

        BUSY: begin
          r_acc    <= w_acc_nxt;
          r_mcand  <= w_mcand_nxt;
          r_mplier <= w_mplier_nxt;
          r_count  <= r_count + 1'b1;
          if (w_last) begin
            r_state  <= DONE;
            r_done   <= 1'b1;
            r_result <= w_acc_nxt;
          end
        end

        DONE: begin
          // Unconditional single-cycle state; start here is ignored.
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end

        default: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule : mul_sequencer

// File: tb/tb_mul_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mul_sequencer
// Directed self-checking bench for mul_sequencer (WIDTH=32). Latency
// expectations follow the build: fixed 33 cycles by default, or
// (highest set bit of opb + 2) cycles when MUL_EARLY_EXIT_EN is defined.
// -----------------------------------------------------------------------------
module tb_mul_sequencer;

  localparam int W = 32;

`ifdef MUL_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  mul_sequencer_if #(.WIDTH(W)) bus ();

  mul_sequencer #(.WIDTH(W)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Cycles from issue to the done cycle: DONE plus the BUSY iterations.
  function automatic int lat_of(input logic [31:0] b);
    int hi;
    hi = -1;
    for (int i = 0; i < W; i++) if (b[i]) hi = i;
    return EARLY ? (hi + 2) : (W + 1);
  endfunction

  // Issue one MUL from IDLE and follow it to retire.
  task automatic do_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp);
    int want, lat, seen, stall_cnt;
    logic [31:0] res;
    want = lat_of(b);
    lat = 0; seen = 0; res = '0;
    bus.opa = a; bus.opb = b; bus.start = 1'b1;
    #1;
    stall_cnt = bus.stall ? 1 : 0;
    for (int i = 1; i <= 40 && seen == 0; i++) begin
      tick();
      bus.start = 1'b0;
      #1;
      if (bus.stall) stall_cnt++;
      if (bus.done) begin
        seen = 1;
        lat  = i;
        res  = bus.result;
      end
    end
    check({tag, "_latency"}, 32'(lat), 32'(want));
    check({tag, "_result"}, res, exp);
    check({tag, "_stall_cycles"}, 32'(stall_cnt), 32'(want));
    tick();
    #1;
    check({tag, "_done_clear"}, 32'(bus.done), 32'd0);
    check({tag, "_busy_clear"}, 32'(bus.busy), 32'd0);
    check({tag, "_result_hold"}, bus.result, exp);
  endtask

  initial begin
    int ndone, first, second, want;

    rst = 1'b1;
    bus.start = 1'b0; bus.flush = 1'b0; bus.opa = '0; bus.opb = '0;
    repeat (3) tick();
    #1;
    check("reset_done",   32'(bus.done),  32'd0);
    check("reset_busy",   32'(bus.busy),  32'd0);
    check("reset_stall",  32'(bus.stall), 32'd0);
    check("reset_result", bus.result,     32'd0);
    rst = 1'b0;
    tick();

    do_mul("mul_3x5",      32'd3,          32'd5,          32'd15);
    do_mul("mul_m1x2",     32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFE);
    do_mul("mul_m3x7",     32'hFFFF_FFFD,  32'd7,          32'hFFFF_FFEB);
    do_mul("mul_ffffx",    32'h0000_FFFF,  32'h0001_0001,  32'hFFFF_FFFF);
    do_mul("mul_opb0",     32'd5,          32'd0,          32'd0);
    do_mul("mul_9x1",      32'd9,          32'd1,          32'd9);
    do_mul("mul_msb",      32'd3,          32'h8000_0000,  32'h8000_0000);

    // flush has priority over start in IDLE
    bus.opa = 32'd1; bus.opb = 32'd1; bus.start = 1'b1; bus.flush = 1'b1;
    #1;
    check("flush_start_stall", 32'(bus.stall), 32'd0);
    tick();
    bus.start = 1'b0; bus.flush = 1'b0;
    #1;
    check("flush_start_busy", 32'(bus.busy), 32'd0);
    ndone = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.done) ndone++;
    end
    check("flush_start_no_done", 32'(ndone), 32'd0);

    // start held high through BUSY and DONE: one done per accepted start
    want = lat_of(32'd3);
    bus.opa = 32'd2; bus.opb = 32'd3; bus.start = 1'b1;
    ndone = 0; first = 0; second = 0;
    for (int i = 1; i <= 2 * want + 2; i++) begin
      tick();
      if (bus.done) begin
        ndone++;
        if (ndone == 1) first = i;
        else if (ndone == 2) second = i;
        check("held_result", bus.result, 32'd6);
      end
    end
    bus.start = 1'b0;
    check("held_done_count",  32'(ndone),  32'd2);
    check("held_first_done",  32'(first),  32'(want));
    check("held_second_done", 32'(second), 32'(2 * want + 1));
    tick();
    check("held_idle", 32'(bus.busy), 32'd0);

    // flush in the middle of BUSY
    bus.opa = 32'd6; bus.opb = 32'h8000_0001; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    check("flush_pre_busy", 32'(bus.busy), 32'd1);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    #1;
    check("flush_busy",   32'(bus.busy),  32'd0);
    check("flush_stall",  32'(bus.stall), 32'd0);
    check("flush_done",   32'(bus.done),  32'd0);
    check("flush_result", bus.result,     32'd6);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.done) ndone++;
    end
    check("flush_no_done", 32'(ndone), 32'd0);
    do_mul("mul_4x4", 32'd4, 32'd4, 32'd16);

    // reset in the middle of BUSY
    bus.opa = 32'd7; bus.opb = 32'h8000_0001; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (19) tick();
    rst = 1'b1;
    tick();
    #1;
    check("midrst_done",   32'(bus.done),  32'd0);
    check("midrst_busy",   32'(bus.busy),  32'd0);
    check("midrst_stall",  32'(bus.stall), 32'd0);
    check("midrst_result", bus.result,     32'd0);
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.done) ndone++;
    end
    check("midrst_no_done", 32'(ndone), 32'd0);
    do_mul("mul_shift", 32'h1234_5678, 32'h0000_0010, 32'h2345_6780);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_mul_sequencer
